dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: a 2-entry in-order write buffer with load forwarding,
// plus a three-state read FSM that services load misses from a ready-handshaked RAM.
module dmem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        addr_err,
  output logic        ram_en,
  output logic        ram_we,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [1:0]  buf_vld_r;   // bit 0 is the head (oldest); bit 1 implies bit 0
  logic [29:0] buf0_addr_r;
  logic [31:0] buf0_data_r;
  logic [29:0] buf1_addr_r;
  logic [31:0] buf1_data_r;
  logic [31:0] rdata_r;
  logic        addr_err_r;

  logic aligned_s;
  logic load_s;
  logic store_s;
  logic full_s;
  logic hit0_s;
  logic hit1_s;
  logic miss_s;
  logic push_s;
  logic pop_s;

  // Request decode and write-buffer address match
  always_comb begin
    aligned_s = (cpu_addr[1:0] == 2'b00);
    load_s    = cpu_en & aligned_s & ~cpu_we;
    store_s   = cpu_en & aligned_s & cpu_we;
    full_s    = buf_vld_r[0] & buf_vld_r[1];
    hit0_s    = buf_vld_r[0] & (buf0_addr_r == cpu_addr[31:2]);
    hit1_s    = buf_vld_r[1] & (buf1_addr_r == cpu_addr[31:2]);
  end

  // CPU response and RAM request steering
  always_comb begin
    cpu_rdata = 32'h0000_0000;
    cpu_stall = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = 30'h0000_0000;
    ram_wdata = 32'h0000_0000;
    miss_s    = 1'b0;
    push_s    = 1'b0;
    if (rst) begin
      cpu_stall = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_s & ~(hit0_s | hit1_s)) begin
            miss_s    = 1'b1;
            ram_en    = 1'b1;
            ram_addr  = cpu_addr[31:2];
            cpu_stall = 1'b1;
          end else if (load_s) begin
            cpu_rdata = hit1_s ? buf1_data_r : buf0_data_r;
          end else if (store_s) begin
            cpu_stall = full_s;
            push_s    = ~full_s;
          end else begin
            cpu_stall = 1'b0;
          end
          // Any load presented to us (hit, miss or misaligned) holds off draining
          if (~(cpu_en & ~cpu_we) & buf_vld_r[0]) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = buf0_addr_r;
            ram_wdata = buf0_data_r;
          end else begin
            ram_we = 1'b0;
          end
        end
        WAIT: begin
          cpu_stall = cpu_en;
        end
        DONE: begin
          cpu_rdata = rdata_r;
        end
        default: begin
          cpu_stall = 1'b0;
        end
      endcase
    end
  end

  assign pop_s    = ram_en & ram_we & ram_ready;
  assign addr_err = addr_err_r;

  // Read FSM, load data capture, misalignment flag and write-buffer update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      buf_vld_r  <= 2'b00;
      rdata_r    <= 32'h0000_0000;
      addr_err_r <= 1'b0;
    end else begin
      addr_err_r <= cpu_en & ~aligned_s;
      case (state_r)
        IDLE: begin
          if (miss_s & ram_ready) begin
            state_r <= WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          rdata_r <= ram_rdata;
          state_r <= DONE;
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
      // A push can only coincide with a pop when exactly one entry is held
      if (pop_s) begin
        if (push_s) begin
          buf0_addr_r <= cpu_addr[31:2];
          buf0_data_r <= cpu_wdata;
          buf_vld_r   <= 2'b01;
        end else begin
          buf0_addr_r <= buf1_addr_r;
          buf0_data_r <= buf1_data_r;
          buf_vld_r   <= {1'b0, buf_vld_r[1]};
        end
      end else if (push_s) begin
        if (buf_vld_r[0]) begin
          buf1_addr_r  <= cpu_addr[31:2];
          buf1_data_r  <= cpu_wdata;
          buf_vld_r[1] <= 1'b1;
        end else begin
          buf0_addr_r  <= cpu_addr[31:2];
          buf0_data_r  <= cpu_wdata;
          buf_vld_r[0] <= 1'b1;
        end
      end else begin
        buf_vld_r <= buf_vld_r;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: bench acts as core and RAM; loads are scored against an
// architectural memory image that every accepted store updates immediately.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_en = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        addr_err;
  logic        ram_en;
  logic        ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic        ram_ready;
  logic        rdy_rand = 1'b0;
  logic        rdy_val = 1'b0;
  logic        rnd_bit = 1'b0;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] mem  [256];
  logic [31:0] gold [256];
  logic [31:0] sbq  [$];
  logic        mon_on = 1'b0;
  logic        pend_err = 1'b0;
  logic        acc_r = 1'b0;
  logic        acc_we = 1'b0;
  logic [29:0] acc_addr = 30'h0;
  logic [31:0] acc_wd = 32'h0;

  dmem_ctrl dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .addr_err(addr_err), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  assign ram_ready = rdy_rand ? rnd_bit : rdy_val;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endfunction

  // RAM model: request sampled mid-cycle, acted on at the accepting edge
  always @(negedge clk) begin
    acc_r    = ram_en & ram_ready;
    acc_we   = ram_we;
    acc_addr = ram_addr;
    acc_wd   = ram_wdata;
  end

  always @(posedge clk) begin
    if (acc_r) begin
      if (acc_we) mem[acc_addr[7:0]] = acc_wd;
      else ram_rdata = mem[acc_addr[7:0]];
    end
  end

  // Architectural memory: an accepted store is visible to every later load
  always @(negedge clk) begin
    if (!rst && cpu_en && cpu_we && cpu_addr[1:0] == 2'b00 && !cpu_stall)
      gold[cpu_addr[9:2]] = cpu_wdata;
  end

  // Monitor: scores returned loads and per-cycle output rules
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      check("addr_err", 32'(addr_err), 32'(pend_err));
      if (!cpu_en) begin
        check("idle_stall", 32'(cpu_stall), 32'h0);
        check("idle_rdata", cpu_rdata, 32'h0);
      end else if (cpu_addr[1:0] != 2'b00) begin
        check("misalign_stall", 32'(cpu_stall), 32'h0);
        check("misalign_rdata", cpu_rdata, 32'h0);
      end else if (!cpu_we && !cpu_stall) begin
        if (sbq.size() == 0) begin
          n_chk++;
          $display("FAIL load_return: got 0x%08h, expected no load pending", cpu_rdata);
        end else begin
          check("load_data", cpu_rdata, sbq.pop_front());
        end
      end
    end
    pend_err = !rst && cpu_en && (cpu_addr[1:0] != 2'b00);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic we, input logic [31:0] a, input logic [31:0] wd);
    cpu_en    = en;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    if (en && !we && a[1:0] == 2'b00) sbq.push_back(gold[a[9:2]]);
  endtask

  task automatic run_req(input logic en, input logic we, input logic [31:0] a, input logic [31:0] wd);
    logic done;
    done = 1'b0;
    drive(en, we, a, wd);
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      done = !cpu_stall;
      step();
    end
    cpu_en = 1'b0;
    if (!done) begin
      n_chk++;
      $display("FAIL stall_timeout: still stalled after 64 cycles, expected release");
    end
  endtask

  task automatic resync();
    sbq.delete();
    for (int i = 0; i < 256; i++) gold[i] = mem[i];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_en = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 32'h0000_0040;
    @(negedge clk);
    check("rst_stall", 32'(cpu_stall), 32'h0);
    check("rst_ram_en", 32'(ram_en), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    step();
    rst = 1'b0;
    cpu_en = 1'b0;
    resync();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000ns, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    do_reset();
    mon_on = 1'b1;

    // store then load of the same word is forwarded from the buffer
    rdy_val = 1'b0;
    run_req(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    @(negedge clk);
    check("fwd_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("fwd_stall", 32'(cpu_stall), 32'h0);
    check("fwd_ram_en", 32'(ram_en), 32'h0);
    step();
    cpu_en = 1'b0;
    do_reset();

    // buffer full: third store waits until the head drains
    rdy_val = 1'b0;
    run_req(1'b1, 1'b1, 32'h0000_0000, 32'hA0A0_0000);
    run_req(1'b1, 1'b1, 32'h0000_0004, 32'hB1B1_0004);
    drive(1'b1, 1'b1, 32'h0000_0008, 32'hC2C2_0008);
    @(negedge clk);
    check("full_stall", 32'(cpu_stall), 32'h1);
    step();
    rdy_val = 1'b1;
    @(negedge clk);
    check("full_stall_pop", 32'(cpu_stall), 32'h1);
    check("drain_en", 32'(ram_en & ram_we), 32'h1);
    check("drain_addr", 32'(ram_addr), 32'h0);
    check("drain_data", ram_wdata, 32'hA0A0_0000);
    step();
    @(negedge clk);
    check("full_accept", 32'(cpu_stall), 32'h0);
    step();
    cpu_en = 1'b0;
    repeat (4) step();
    check("drain_mem0", mem[0], 32'hA0A0_0000);
    check("drain_mem1", mem[1], 32'hB1B1_0004);
    check("drain_mem2", mem[2], 32'hC2C2_0008);
    do_reset();

    // load miss with an always-ready RAM
    rdy_val = 1'b1;
    mem[16] = 32'h1234_5678;
    gold[16] = 32'h1234_5678;
    drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    @(negedge clk);
    check("miss_ram_addr", 32'(ram_addr), 32'h10);
    check("miss_ram_rd", 32'({ram_en, ram_we}), 32'h2);
    check("miss_stall1", 32'(cpu_stall), 32'h1);
    step();
    @(negedge clk);
    check("miss_stall2", 32'(cpu_stall), 32'h1);
    step();
    @(negedge clk);
    check("miss_stall3", 32'(cpu_stall), 32'h0);
    check("miss_rdata", cpu_rdata, 32'h1234_5678);
    step();
    cpu_en = 1'b0;

    // misaligned load
    drive(1'b1, 1'b0, 32'h0000_0102, 32'h0);
    @(negedge clk);
    check("mis_stall", 32'(cpu_stall), 32'h0);
    check("mis_ram_en", 32'(ram_en), 32'h0);
    step();
    cpu_en = 1'b0;
    @(negedge clk);
    check("mis_err_pulse", 32'(addr_err), 32'h1);
    check("mis_ram_en2", 32'(ram_en), 32'h0);
    step();
    @(negedge clk);
    check("mis_err_clear", 32'(addr_err), 32'h0);
    step();

    // reset while the read FSM is waiting
    rdy_val = 1'b0;
    run_req(1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_0001);
    drive(1'b1, 1'b0, 32'h0000_0044, 32'h0);
    rdy_val = 1'b1;
    @(negedge clk);
    check("abort_issue_stall", 32'(cpu_stall), 32'h1);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst_stall", 32'(cpu_stall), 32'h0);
    check("abort_rst_ram_en", 32'(ram_en), 32'h0);
    step();
    rst = 1'b0;
    cpu_en = 1'b0;
    resync();
    @(negedge clk);
    check("abort_post_stall", 32'(cpu_stall), 32'h0);
    check("abort_post_rdata", cpu_rdata, 32'h0);
    check("abort_post_empty", 32'(ram_en), 32'h0);
    step();

    // load miss wins over a pending drain
    rdy_val = 1'b0;
    run_req(1'b1, 1'b1, 32'h0000_0030, 32'hBEEF_0030);
    drive(1'b1, 1'b0, 32'h0000_0050, 32'h0);
    rdy_val = 1'b1;
    @(negedge clk);
    check("prio_read", 32'({ram_en, ram_we}), 32'h2);
    check("prio_addr", 32'(ram_addr), 32'h14);
    step();
    @(negedge clk);
    check("prio_wait_idle", 32'(ram_en), 32'h0);
    step();
    @(negedge clk);
    check("prio_done_idle", 32'(ram_en), 32'h0);
    check("prio_done_stall", 32'(cpu_stall), 32'h0);
    step();
    cpu_en = 1'b0;
    @(negedge clk);
    check("prio_resume", 32'({ram_en, ram_we}), 32'h3);
    check("prio_resume_addr", 32'(ram_addr), 32'hC);
    check("prio_resume_data", ram_wdata, 32'hBEEF_0030);
    step();

    // randomized traffic over 16 words with a random ready pattern
    rdy_rand = 1'b1;
    for (int t = 0; t < 400; t++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 99);
      a = 32'($urandom_range(0, 15)) << 2;
      if (r < 5) run_req(1'b0, 1'b0, 32'h0, 32'h0);
      else if (r < 10) run_req(1'b1, 1'($urandom_range(0, 1)), a | 32'($urandom_range(1, 3)), $urandom);
      else if (r < 50) run_req(1'b1, 1'b1, a, $urandom);
      else if (r < 99) run_req(1'b1, 1'b0, a, 32'h0);
      else do_reset();
    end

    // let the buffer drain, then RAM must equal the architectural image
    rdy_rand = 1'b0;
    rdy_val = 1'b1;
    cpu_en = 1'b0;
    repeat (6) step();
    for (int i = 0; i < 16; i++) check($sformatf("final_mem[%0d]", i), mem[i], gold[i]);
    check("sb_empty", 32'(sbq.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
